rob_recovery_ctrl: RTL and testbench
====================================

# rob_recovery_ctrl

Sequences branch-mispredict recovery of the reorder buffer. It accepts one rollback request and walks the squashed ROB entries from newest (tail-1) back to the first squashed index, two entries per cycle. For each entry it broadcasts T_idx, Told_idx and dest_idx so the map table can restore mappings and the free list can reclaim registers. It stalls dispatch for the whole walk, then issues a one-cycle tail-restore to the ROB.

## Interface
- NUM_ROB, 32, ROB depth; power of two; indices wrap mod NUM_ROB
- NUM_SUPER, 2, entries walked per cycle; fixed at 2
- NUM_PR, 64, physical registers; tag width $clog2(NUM_PR)
- ZERO_REG, 31, architectural zero register
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- en  in  1  global advance; when low, all state holds and outputs hold
- rollback_en  in  1  rollback request; held until accepted
- rollback_idx  in  $clog2(NUM_ROB)  first squashed index (branch idx + 1)
- rob_tail  in  $clog2(NUM_ROB)  current ROB tail, sampled at acceptance
- rollback_ready  out  1  high only in IDLE; accept = rollback_en & rollback_ready & en
- rd_idx  out  NUM_SUPER x $clog2(NUM_ROB)  ROB read addresses; combinational read, same cycle
- rd_valid, rd_T_idx, rd_Told_idx, rd_dest_idx  in  NUM_SUPER x (1, PR, PR, 5)  ROB read data
- walk_valid  out  NUM_SUPER  slot carries a squashed entry this cycle
- walk_T_idx, walk_Told_idx, walk_dest_idx  out  NUM_SUPER x (PR, PR, 5)  squashed entry fields; slot 0 is newer
- walk_free  out  NUM_SUPER  walk_valid & dest_idx != ZERO_REG; free list reclaims T_idx
- stall_dispatch  out  1  dispatch blocked
- tail_restore_valid  out  1  one-cycle pulse; ROB sets tail = tail_restore_idx
- tail_restore_idx  out  $clog2(NUM_ROB)  latched rollback_idx
- walk_err  out  1  sticky; a walked slot read rd_valid=0

## Operation
- States: IDLE, WALK, DONE.
- IDLE, on accept: latch stop_idx = rollback_idx, ptr = rob_tail - 1, count = (rob_tail - rollback_idx) mod NUM_ROB (width $clog2(NUM_ROB)+1). If count == 0, go to DONE; otherwise go to WALK.
- WALK: rd_idx[0] = ptr, rd_idx[1] = ptr - 1.
  - walk_valid[0] = (count >= 1); walk_valid[1] = (count >= 2).
  - ptr -= 2; count -= min(2, count).
  - When the updated count == 0, go to DONE.
- DONE: tail_restore_valid = 1 with tail_restore_idx = stop_idx; return to IDLE.
- Map-table restore order is newest first. Consecutive writes to the same dest therefore leave the oldest squashed Told_idx.
- walk_err sets if any walk_valid slot sees rd_valid = 0. The entry is still emitted. walk_err clears only on reset.
- rollback_en outside IDLE is not accepted. The requester holds it (or drops it if the branch is itself squashed).
- stall_dispatch = (state != IDLE) | (rollback_en & rollback_ready).

## Timing
- Reset values:
  - state IDLE; ptr, count, stop_idx = 0.
  - rollback_ready = 1.
  - walk_valid, walk_free, tail_restore_valid, walk_err, stall_dispatch = 0.
  - rd_idx = 0.
- Latency for N squashed entries: accept cycle, then ceil(N/2) WALK cycles, then 1 DONE cycle. rollback_ready returns high the cycle after DONE.
- Odd N: the final WALK cycle has walk_valid = 2'b01.
- N = 0: accept, then DONE next cycle, with no walk output.
- Ptr wrap-around 0 -> NUM_ROB-1 is a natural modulo decrement. Maximum N = NUM_ROB-1 (the branch entry always survives).
- en low: no state update. Walk outputs repeat the same entries but are not re-consumed, because consumers are gated by the same en.
- Reset mid-walk: returns to IDLE the next cycle, with no tail_restore pulse.

## Structure
- Shared package holds:
  - ROB_RECOV_STATE_t (enum IDLE/WALK/DONE);
  - ROB_WALK_OUT_t, packing walk_valid/free/T/Told/dest per slot, consumed by map table and free list;
  - ROB_RECOV_ROB_OUT_t (rd_idx, tail_restore);
  - ZERO_REG.
- No sub-module. The distance computation is a package function rob_dist(tail, idx) returning (tail - idx) mod NUM_ROB.

## Test plan
- Request: tail = 10, rollback_idx = 6 -> WALK reads (9,8), then (7,6); 2 WALK cycles; DONE pulse with tail_restore_idx = 6; stall_dispatch high 4 cycles.
- Request: tail = 2, rollback_idx = 29 -> N = 5; walk order 1,0,31,30,29; last cycle walk_valid = 2'b01.
- Request: tail = 7, rollback_idx = 7 -> no walk_valid; DONE on cycle 2; rollback_ready high on cycle 3.
- Second rollback_en asserted during WALK -> not accepted; accepted the cycle after returning to IDLE.
- Walked entry with dest_idx = 31 -> walk_valid = 1, walk_free = 0. An entry with rd_valid = 0 -> walk_err = 1 and stays set.
- en low for 3 cycles mid-walk, then reset asserted during WALK -> count/ptr frozen while en is low; after reset: IDLE, no tail_restore, all outputs at reset values.

Source files
------------

// File: rtl/rob_recovery_ctrl_pkg.sv
// Shared types and constants for ROB mispredict recovery: state encoding,
// walk broadcast bundle, ROB-facing bundle and ring-distance helper.
package rob_recovery_ctrl_pkg;

    localparam int NUM_ROB   = 32;
    localparam int NUM_SUPER = 2;
    localparam int NUM_PR    = 64;
    localparam int ROB_IDX_W = $clog2(NUM_ROB);
    localparam int PR_W      = $clog2(NUM_PR);
    localparam int ARCH_W    = 5;
    localparam int CNT_W     = ROB_IDX_W + 1;

    localparam logic [ARCH_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } ROB_RECOV_STATE_t;

    // Per-slot squashed entry broadcast; slot 0 is the newer entry.
    typedef struct packed {
        logic [NUM_SUPER-1:0]             valid;
        logic [NUM_SUPER-1:0]             free;
        logic [NUM_SUPER-1:0][PR_W-1:0]   T_idx;
        logic [NUM_SUPER-1:0][PR_W-1:0]   Told_idx;
        logic [NUM_SUPER-1:0][ARCH_W-1:0] dest_idx;
    } ROB_WALK_OUT_t;

    typedef struct packed {
        logic [NUM_SUPER-1:0][ROB_IDX_W-1:0] rd_idx;
        logic                                tail_restore_valid;
        logic [ROB_IDX_W-1:0]                tail_restore_idx;
    } ROB_RECOV_ROB_OUT_t;

    // Number of entries from idx up to (not including) tail on the ring.
    function automatic logic [CNT_W-1:0] rob_dist(input logic [ROB_IDX_W-1:0] tail,
                                                  input logic [ROB_IDX_W-1:0] idx);
        logic [ROB_IDX_W-1:0] d;
        d = tail - idx;
        return {1'b0, d};
    endfunction

endpackage

// File: rtl/rob_recovery_ctrl.sv
// Walks squashed ROB entries newest-first, two per cycle, broadcasting them to
// the map table and free list, then pulses a tail restore back to the ROB.
module rob_recovery_ctrl
    import rob_recovery_ctrl_pkg::*;
(
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic                                 rollback_en,
    input  logic [ROB_IDX_W-1:0]                 rollback_idx,
    input  logic [ROB_IDX_W-1:0]                 rob_tail,
    output logic                                 rollback_ready,
    output logic [NUM_SUPER-1:0][ROB_IDX_W-1:0]  rd_idx,
    input  logic [NUM_SUPER-1:0]                 rd_valid,
    input  logic [NUM_SUPER-1:0][PR_W-1:0]       rd_T_idx,
    input  logic [NUM_SUPER-1:0][PR_W-1:0]       rd_Told_idx,
    input  logic [NUM_SUPER-1:0][ARCH_W-1:0]     rd_dest_idx,
    output logic [NUM_SUPER-1:0]                 walk_valid,
    output logic [NUM_SUPER-1:0][PR_W-1:0]       walk_T_idx,
    output logic [NUM_SUPER-1:0][PR_W-1:0]       walk_Told_idx,
    output logic [NUM_SUPER-1:0][ARCH_W-1:0]     walk_dest_idx,
    output logic [NUM_SUPER-1:0]                 walk_free,
    output logic                                 stall_dispatch,
    output logic                                 tail_restore_valid,
    output logic [ROB_IDX_W-1:0]                 tail_restore_idx,
    output logic                                 walk_err
);

    localparam logic [ROB_IDX_W-1:0] IDX_ONE = 1;
    localparam logic [ROB_IDX_W-1:0] IDX_TWO = 2;
    localparam logic [CNT_W-1:0]     CNT_TWO = 2;

    ROB_RECOV_STATE_t     state_q, state_d;
    logic [ROB_IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ROB_IDX_W-1:0] stop_idx_q, stop_idx_d;
    logic                 walk_err_q, walk_err_d;

    logic                 accept;
    logic [CNT_W-1:0]     take;
    ROB_WALK_OUT_t        walk;
    ROB_RECOV_ROB_OUT_t   rob_out;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        stop_idx_d = stop_idx_q;
        walk_err_d = walk_err_q;
        walk       = '0;
        rob_out    = '0;
        take       = '0;
        accept     = rollback_en & (state_q == IDLE) & en;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    stop_idx_d = rollback_idx;
                    ptr_d      = rob_tail - IDX_ONE;
                    count_d    = rob_dist(rob_tail, rollback_idx);
                    state_d    = (count_d == '0) ? DONE : WALK;
                end
            end
            WALK: begin
                rob_out.rd_idx[0] = ptr_q;
                rob_out.rd_idx[1] = ptr_q - IDX_ONE;
                for (int s = 0; s < NUM_SUPER; s++) begin
                    walk.valid[s]    = count_q > CNT_W'(s);
                    walk.T_idx[s]    = rd_T_idx[s];
                    walk.Told_idx[s] = rd_Told_idx[s];
                    walk.dest_idx[s] = rd_dest_idx[s];
                    walk.free[s]     = walk.valid[s] & (rd_dest_idx[s] != ZERO_REG);
                    // A hole in the squashed range is flagged but the entry is still broadcast.
                    if (en && walk.valid[s] && !rd_valid[s]) begin
                        walk_err_d = 1'b1;
                    end
                end
                take = (count_q >= CNT_TWO) ? CNT_TWO : count_q;
                if (en) begin
                    ptr_d   = ptr_q - IDX_TWO;
                    count_d = count_q - take;
                    if (count_d == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                rob_out.tail_restore_valid = 1'b1;
                rob_out.tail_restore_idx   = stop_idx_q;
                if (en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            stop_idx_q <= '0;
            walk_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            stop_idx_q <= stop_idx_d;
            walk_err_q <= walk_err_d;
        end
    end

    assign rollback_ready     = (state_q == IDLE);
    assign stall_dispatch     = (state_q != IDLE) | (rollback_en & rollback_ready);
    assign rd_idx             = rob_out.rd_idx;
    assign tail_restore_valid = rob_out.tail_restore_valid;
    assign tail_restore_idx   = rob_out.tail_restore_idx;
    assign walk_valid         = walk.valid;
    assign walk_free          = walk.free;
    assign walk_T_idx         = walk.T_idx;
    assign walk_Told_idx      = walk.Told_idx;
    assign walk_dest_idx      = walk.dest_idx;
    assign walk_err           = walk_err_q;

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Cycle-by-cycle vector bench for rob_recovery_ctrl with a small ROB read model.
module tb_rob_recovery_ctrl;

    logic                  clock;
    logic                  reset;
    logic                  en;
    logic                  rollback_en;
    logic [4:0]            rollback_idx;
    logic [4:0]            rob_tail;
    logic                  rollback_ready;
    logic [1:0][4:0]       rd_idx;
    logic [1:0]            rd_valid;
    logic [1:0][5:0]       rd_T_idx;
    logic [1:0][5:0]       rd_Told_idx;
    logic [1:0][4:0]       rd_dest_idx;
    logic [1:0]            walk_valid;
    logic [1:0][5:0]       walk_T_idx;
    logic [1:0][5:0]       walk_Told_idx;
    logic [1:0][4:0]       walk_dest_idx;
    logic [1:0]            walk_free;
    logic                  stall_dispatch;
    logic                  tail_restore_valid;
    logic [4:0]            tail_restore_idx;
    logic                  walk_err;

    logic                  rob_vld [32];
    int                    checks;
    int                    errors;

    rob_recovery_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .en                 (en),
        .rollback_en        (rollback_en),
        .rollback_idx       (rollback_idx),
        .rob_tail           (rob_tail),
        .rollback_ready     (rollback_ready),
        .rd_idx             (rd_idx),
        .rd_valid           (rd_valid),
        .rd_T_idx           (rd_T_idx),
        .rd_Told_idx        (rd_Told_idx),
        .rd_dest_idx        (rd_dest_idx),
        .walk_valid         (walk_valid),
        .walk_T_idx         (walk_T_idx),
        .walk_Told_idx      (walk_Told_idx),
        .walk_dest_idx      (walk_dest_idx),
        .walk_free          (walk_free),
        .stall_dispatch     (stall_dispatch),
        .tail_restore_valid (tail_restore_valid),
        .tail_restore_idx   (tail_restore_idx),
        .walk_err           (walk_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROB contents: T = {1,idx}, Told = {0,idx}, dest = idx (so entry 31 targets the zero reg).
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            rd_T_idx[s]    = {1'b1, rd_idx[s]};
            rd_Told_idx[s] = {1'b0, rd_idx[s]};
            rd_dest_idx[s] = rd_idx[s];
            rd_valid[s]    = rob_vld[rd_idx[s]];
        end
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic       rbe;
        logic [4:0] rbi;
        logic [4:0] tail;
        logic       rdy;
        logic       stall;
        logic [1:0] wv;
        logic [1:0] wf;
        logic [4:0] rd0;
        logic [4:0] rd1;
        logic       trv;
        logic [4:0] tidx;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rst, input logic e, input logic rbe, input int rbi, input int tl,
                       input logic rdy, input logic stall, input logic [1:0] wv, input logic [1:0] wf,
                       input int rd0, input int rd1, input logic trv, input int tidx, input logic err);
        vec_t v;
        v.rst = rst; v.en = e; v.rbe = rbe; v.rbi = 5'(rbi); v.tail = 5'(tl);
        v.rdy = rdy; v.stall = stall; v.wv = wv; v.wf = wf;
        v.rd0 = 5'(rd0); v.rd1 = 5'(rd1); v.trv = trv; v.tidx = 5'(tidx); v.err = err;
        vecs.push_back(v);
    endtask

    initial begin
        logic [22:0] exp_v, act_v;
        logic [16:0] exp_f, act_f;
        logic [4:0]  erd;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) rob_vld[i] = 1'b1;
        rob_vld[13] = 1'b0;

        //   rst en rbe rbi tail | rdy stl wv     wf     rd0 rd1 trv tidx err
        // tail=10, rollback 6
        row(0, 1, 0,  0,  0,  1, 0, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        row(0, 1, 1,  6, 10,  1, 1, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b11, 2'b11,  9,  8, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b11, 2'b11,  7,  6, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b00, 2'b00,  0,  0, 1,  6, 0);
        row(0, 1, 0,  0,  0,  1, 0, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        // tail=2, rollback 29: wraps, N=5, entry 31 is zero-reg
        row(0, 1, 1, 29,  2,  1, 1, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b11, 2'b11,  1,  0, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b11, 2'b10, 31, 30, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b01, 2'b01, 29, 28, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b00, 2'b00,  0,  0, 1, 29, 0);
        row(0, 1, 0,  0,  0,  1, 0, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        // tail=7, rollback 7: empty walk
        row(0, 1, 1,  7,  7,  1, 1, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b00, 2'b00,  0,  0, 1,  7, 0);
        row(0, 1, 0,  0,  0,  1, 0, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        // tail=4, rollback 0; second request (20,25) held during the walk
        row(0, 1, 1,  0,  4,  1, 1, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        row(0, 1, 1, 20, 25,  0, 1, 2'b11, 2'b11,  3,  2, 0,  0, 0);
        row(0, 1, 1, 20, 25,  0, 1, 2'b11, 2'b11,  1,  0, 0,  0, 0);
        row(0, 1, 1, 20, 25,  0, 1, 2'b00, 2'b00,  0,  0, 1,  0, 0);
        row(0, 1, 1, 20, 25,  1, 1, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b11, 2'b11, 24, 23, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b11, 2'b11, 22, 21, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b01, 2'b01, 20, 19, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b00, 2'b00,  0,  0, 1, 20, 0);
        row(0, 1, 0,  0,  0,  1, 0, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        // tail=15, rollback 12: entry 13 invalid -> sticky walk_err
        row(0, 1, 1, 12, 15,  1, 1, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b11, 2'b11, 14, 13, 0,  0, 0);
        row(0, 1, 0,  0,  0,  0, 1, 2'b01, 2'b01, 12, 11, 0,  0, 1);
        row(0, 1, 0,  0,  0,  0, 1, 2'b00, 2'b00,  0,  0, 1, 12, 1);
        row(0, 1, 0,  0,  0,  1, 0, 2'b00, 2'b00,  0,  0, 0,  0, 1);
        // tail=20, rollback 10: en low 3 cycles, then reset mid-walk
        row(0, 1, 1, 10, 20,  1, 1, 2'b00, 2'b00,  0,  0, 0,  0, 1);
        row(0, 1, 0,  0,  0,  0, 1, 2'b11, 2'b11, 19, 18, 0,  0, 1);
        row(0, 0, 0,  0,  0,  0, 1, 2'b11, 2'b11, 17, 16, 0,  0, 1);
        row(0, 0, 0,  0,  0,  0, 1, 2'b11, 2'b11, 17, 16, 0,  0, 1);
        row(0, 0, 0,  0,  0,  0, 1, 2'b11, 2'b11, 17, 16, 0,  0, 1);
        row(0, 1, 0,  0,  0,  0, 1, 2'b11, 2'b11, 17, 16, 0,  0, 1);
        row(1, 1, 0,  0,  0,  0, 1, 2'b11, 2'b11, 15, 14, 0,  0, 1);
        row(0, 1, 0,  0,  0,  1, 0, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        row(0, 1, 0,  0,  0,  1, 0, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        // en low blocks acceptance
        row(0, 0, 1,  3,  5,  1, 1, 2'b00, 2'b00,  0,  0, 0,  0, 0);
        row(0, 0, 0,  0,  0,  1, 0, 2'b00, 2'b00,  0,  0, 0,  0, 0);

        reset        = 1'b1;
        en           = 1'b1;
        rollback_en  = 1'b0;
        rollback_idx = '0;
        rob_tail     = '0;
        repeat (2) @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset        = vecs[i].rst;
            en           = vecs[i].en;
            rollback_en  = vecs[i].rbe;
            rollback_idx = vecs[i].rbi;
            rob_tail     = vecs[i].tail;
            #1;
            exp_v = {vecs[i].rdy, vecs[i].stall, vecs[i].wv, vecs[i].wf, vecs[i].rd0, vecs[i].rd1,
                     vecs[i].trv, vecs[i].tidx, vecs[i].err};
            act_v = {rollback_ready, stall_dispatch, walk_valid, walk_free, rd_idx[0], rd_idx[1],
                     tail_restore_valid, tail_restore_idx, walk_err};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL vec%0d ctrl: got rdy=%b stall=%b wv=%b wf=%b rd=%0d,%0d trv=%b tidx=%0d err=%b want rdy=%b stall=%b wv=%b wf=%b rd=%0d,%0d trv=%b tidx=%0d err=%b",
                         i, rollback_ready, stall_dispatch, walk_valid, walk_free, rd_idx[0], rd_idx[1],
                         tail_restore_valid, tail_restore_idx, walk_err,
                         vecs[i].rdy, vecs[i].stall, vecs[i].wv, vecs[i].wf, vecs[i].rd0, vecs[i].rd1,
                         vecs[i].trv, vecs[i].tidx, vecs[i].err);
            end
            for (int s = 0; s < 2; s++) begin
                if (vecs[i].wv[s]) begin
                    erd   = (s == 0) ? vecs[i].rd0 : vecs[i].rd1;
                    exp_f = {1'b1, erd, 1'b0, erd, erd};
                    act_f = {walk_T_idx[s], walk_Told_idx[s], walk_dest_idx[s]};
                    checks++;
                    if (act_f !== exp_f) begin
                        errors++;
                        $display("FAIL vec%0d slot%0d fields: got T=%0d Told=%0d dest=%0d want T=%0d Told=%0d dest=%0d",
                                 i, s, walk_T_idx[s], walk_Told_idx[s], walk_dest_idx[s],
                                 {1'b1, erd}, {1'b0, erd}, erd);
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
